// File: rtl/in_service_unit.sv
// In-service register tracker for the interrupt controller: records acknowledged levels,
// retires them through EOI commands and owns the rotating-priority pointer.
module in_service_unit #(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               acknowledge,
   input  logic [NUM_IRQ-1:0] ack_vector,
   input  logic               auto_eoi,
   input  logic               auto_rotate,
   input  logic               eoi_valid,
   input  logic [2:0]         eoi_cmd,
   input  logic [IDX_W-1:0]   eoi_level,
   input  logic               special_mask_mode,
   input  logic [NUM_IRQ-1:0] interrupt_mask,
   output logic [NUM_IRQ-1:0] in_service_register,
   output logic [NUM_IRQ-1:0] highest_level_in_service,
   output logic [IDX_W-1:0]   priority_rotate,
   output logic               in_service_any,
   output logic               eoi_error
);

   localparam logic [2:0] CMD_NS_EOI     = 3'b001;
   localparam logic [2:0] CMD_SP_EOI     = 3'b011;
   localparam logic [2:0] CMD_ROT_NS_EOI = 3'b101;
   localparam logic [2:0] CMD_ROT_SP_EOI = 3'b111;
   localparam logic [2:0] CMD_SET_PRIO   = 3'b110;

   logic [NUM_IRQ-1:0]   r_isr;
   logic [IDX_W-1:0]     r_prio;
   logic                 r_eoi_error;

   logic [NUM_IRQ-1:0]   w_isr_next;
   logic [IDX_W-1:0]     w_prio_next;
   logic                 w_err_next;

   logic [NUM_IRQ-1:0]   w_em;
   logic [NUM_IRQ-1:0]   w_masked;
   logic [IDX_W-1:0]     w_shift;
   logic [2*NUM_IRQ-1:0] w_rot_right;
   logic [NUM_IRQ-1:0]   w_rel;
   logic [NUM_IRQ-1:0]   w_rel_low;
   logic [2*NUM_IRQ-1:0] w_rot_left;
   logic [NUM_IRQ-1:0]   w_highest;
   logic [NUM_IRQ-1:0]   w_target;
   logic                 w_ack_onehot;
   logic [NUM_IRQ-1:0]   w_clear;
   logic [NUM_IRQ-1:0]   w_set;

   function automatic logic [IDX_W-1:0] f_index(input logic [NUM_IRQ-1:0] v);
      f_index = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (v[i]) f_index = IDX_W'(i);
      end
   endfunction

   // Priority search happens in a frame where the highest-priority level sits at bit 0;
   // NUM_IRQ is a power of two, so the index addition wraps naturally.
   assign w_em        = special_mask_mode ? interrupt_mask : '0;
   assign w_masked    = r_isr & ~w_em;
   assign w_shift     = r_prio + IDX_W'(1);
   assign w_rot_right = {w_masked, w_masked} >> w_shift;
   assign w_rel       = w_rot_right[NUM_IRQ-1:0];
   assign w_rel_low   = w_rel & (~w_rel + NUM_IRQ'(1));
   assign w_rot_left  = {w_rel_low, w_rel_low} << w_shift;
   assign w_highest   = w_rot_left[2*NUM_IRQ-1:NUM_IRQ];

   assign w_target     = NUM_IRQ'(1) << eoi_level;
   assign w_ack_onehot = (ack_vector != '0) &&
                         ((ack_vector & (ack_vector - NUM_IRQ'(1))) == '0);

   always_comb begin
      w_clear     = '0;
      w_set       = '0;
      w_prio_next = r_prio;
      w_err_next  = 1'b0;

      if (eoi_valid) begin
         case (eoi_cmd)
            CMD_NS_EOI, CMD_ROT_NS_EOI: begin
               if (w_highest == '0) begin
                  w_err_next = 1'b1;
               end else begin
                  w_clear = w_highest;
                  if (eoi_cmd[2]) w_prio_next = f_index(w_highest);
               end
            end
            CMD_SP_EOI, CMD_ROT_SP_EOI: begin
               if ((r_isr & w_target) == '0) w_err_next = 1'b1;
               else                          w_clear    = w_target;
               if (eoi_cmd[2]) w_prio_next = eoi_level;
            end
            CMD_SET_PRIO: w_prio_next = eoi_level;
            default: ;
         endcase
      end

      // Acknowledge is applied last so its AEOI rotation overrides any EOI rotation.
      if (acknowledge) begin
         if (!w_ack_onehot) begin
            w_err_next = 1'b1;
         end else if (!auto_eoi) begin
            w_set = ack_vector;
         end else if (auto_rotate) begin
            w_prio_next = f_index(ack_vector);
         end
      end

      w_isr_next = (r_isr & ~w_clear) | w_set;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_isr       <= '0;
         r_prio      <= IDX_W'(NUM_IRQ - 1);
         r_eoi_error <= 1'b0;
      end else begin
         r_isr       <= w_isr_next;
         r_prio      <= w_prio_next;
         r_eoi_error <= w_err_next;
      end
   end

   assign in_service_register      = r_isr;
   assign highest_level_in_service = w_highest;
   assign priority_rotate          = r_prio;
   assign in_service_any           = |w_masked;
   assign eoi_error                = r_eoi_error;

endmodule

// File: tb/tb_in_service_unit.sv
// Bench for in_service_unit: directed walk through the main scenarios, then randomized
// traffic checked against a priority-order reference model.
module tb_in_service_unit;

   localparam int N = 8;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         acknowledge;
   logic [N-1:0] ack_vector;
   logic         auto_eoi;
   logic         auto_rotate;
   logic         eoi_valid;
   logic [2:0]   eoi_cmd;
   logic [2:0]   eoi_level;
   logic         special_mask_mode;
   logic [N-1:0] interrupt_mask;
   logic [N-1:0] in_service_register;
   logic [N-1:0] highest_level_in_service;
   logic [2:0]   priority_rotate;
   logic         in_service_any;
   logic         eoi_error;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   logic [N-1:0] m_isr;
   int           m_prio;
   logic         m_err;

   in_service_unit #(.NUM_IRQ(N)) dut (
      .clock                    (clock),
      .reset_n                  (reset_n),
      .acknowledge              (acknowledge),
      .ack_vector               (ack_vector),
      .auto_eoi                 (auto_eoi),
      .auto_rotate              (auto_rotate),
      .eoi_valid                (eoi_valid),
      .eoi_cmd                  (eoi_cmd),
      .eoi_level                (eoi_level),
      .special_mask_mode        (special_mask_mode),
      .interrupt_mask           (interrupt_mask),
      .in_service_register      (in_service_register),
      .highest_level_in_service (highest_level_in_service),
      .priority_rotate          (priority_rotate),
      .in_service_any           (in_service_any),
      .eoi_error                (eoi_error)
   );

   always #5 clock = ~clock;

   // Walk levels from highest priority (prio+1) to lowest, skipping masked ones.
   function automatic logic [N-1:0] model_h();
      logic [N-1:0] em;
      logic [N-1:0] r;
      em = special_mask_mode ? interrupt_mask : '0;
      r  = '0;
      for (int k = 1; k <= N; k++) begin
         int l;
         l = (m_prio + k) % N;
         if (m_isr[l] && !em[l]) begin
            r[l] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_clock();
      logic [N-1:0] h;
      logic [N-1:0] clr;
      logic [N-1:0] set;
      int           np;
      logic         err;
      if (!reset_n) begin
         m_isr  = '0;
         m_prio = N - 1;
         m_err  = 1'b0;
         return;
      end
      h   = model_h();
      clr = '0;
      set = '0;
      np  = m_prio;
      err = 1'b0;
      if (eoi_valid) begin
         case (eoi_cmd)
            3'b001, 3'b101: begin
               if (h == '0) err = 1'b1;
               else begin
                  clr = h;
                  if (eoi_cmd == 3'b101) np = $clog2(h);
               end
            end
            3'b011, 3'b111: begin
               if (!m_isr[eoi_level]) err = 1'b1;
               else clr[eoi_level] = 1'b1;
               if (eoi_cmd == 3'b111) np = int'(eoi_level);
            end
            3'b110: np = int'(eoi_level);
            default: ;
         endcase
      end
      if (acknowledge) begin
         if ($countones(ack_vector) != 1) err = 1'b1;
         else if (!auto_eoi) set = ack_vector;
         else if (auto_rotate) np = $clog2(ack_vector);
      end
      m_isr  = (m_isr & ~clr) | set;
      m_prio = np;
      m_err  = err;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".isr"},  32'(in_service_register),      32'(m_isr));
      check({tag, ".h"},    32'(highest_level_in_service), 32'(model_h()));
      check({tag, ".prio"}, 32'(priority_rotate),          32'(m_prio));
      check({tag, ".any"},  32'(in_service_any),           32'(|(model_h())));
      check({tag, ".err"},  32'(eoi_error),                32'(m_err));
   endtask

   task automatic idle_inputs();
      acknowledge = 1'b0;
      ack_vector  = '0;
      eoi_valid   = 1'b0;
      eoi_cmd     = 3'b000;
      eoi_level   = 3'd0;
   endtask

   // One clock: model advances on the same edge, outputs sampled 1 time unit later.
   task automatic step(input string tag);
      @(posedge clock);
      model_clock();
      #1;
      step_no++;
      $display("step %0d %s: rst_n=%b ack=%b vec=%h eoi=%b cmd=%b lvl=%0d -> isr=%h h=%h prio=%0d err=%b",
               step_no, tag, reset_n, acknowledge, ack_vector, eoi_valid, eoi_cmd, eoi_level,
               in_service_register, highest_level_in_service, priority_rotate, eoi_error);
      check_all(tag);
      idle_inputs();
   endtask

   task automatic do_ack(input logic [N-1:0] v, input string tag);
      acknowledge = 1'b1;
      ack_vector  = v;
      step(tag);
   endtask

   task automatic do_eoi(input logic [2:0] cmd, input logic [2:0] lvl, input string tag);
      eoi_valid = 1'b1;
      eoi_cmd   = cmd;
      eoi_level = lvl;
      step(tag);
   endtask

   initial begin
      reset_n           = 1'b0;
      auto_eoi          = 1'b0;
      auto_rotate       = 1'b0;
      special_mask_mode = 1'b0;
      interrupt_mask    = '0;
      m_isr             = '0;
      m_prio            = 0;
      m_err             = 1'b0;
      idle_inputs();
      @(negedge clock);

      step("reset");
      step("reset2");
      check("reset.prio_const", 32'(priority_rotate), 32'd7);
      reset_n = 1'b1;

      do_ack(8'h08, "ack3");
      do_ack(8'h20, "ack5");
      check("fixed.isr_const", 32'(in_service_register), 32'h28);
      check("fixed.h_const", 32'(highest_level_in_service), 32'h08);
      do_eoi(3'b001, 3'd0, "ns_eoi");
      check("ns_eoi.isr_const", 32'(in_service_register), 32'h20);
      check("ns_eoi.h_const", 32'(highest_level_in_service), 32'h20);

      do_ack(8'h08, "ack3b");
      do_eoi(3'b101, 3'd0, "rot_ns_eoi");
      check("rot_ns.prio_const", 32'(priority_rotate), 32'd3);
      check("rot_ns.isr_const", 32'(in_service_register), 32'h20);
      do_ack(8'h02, "ack1");
      check("rot_ns.h_const", 32'(highest_level_in_service), 32'h20);

      do_eoi(3'b011, 3'd6, "sp_eoi_miss");
      check("sp_miss.err_const", 32'(eoi_error), 32'd1);
      step("idle_err_clear");
      do_eoi(3'b110, 3'd2, "set_prio");
      check("set_prio.prio_const", 32'(priority_rotate), 32'd2);
      do_eoi(3'b011, 3'd5, "sp_eoi5");
      do_eoi(3'b011, 3'd1, "sp_eoi1");

      auto_eoi    = 1'b1;
      auto_rotate = 1'b1;
      do_ack(8'h10, "aeoi_ack4");
      check("aeoi.prio_const", 32'(priority_rotate), 32'd4);
      do_ack(8'h06, "bad_ack");
      check("bad_ack.err_const", 32'(eoi_error), 32'd1);
      auto_eoi    = 1'b0;
      auto_rotate = 1'b0;

      do_eoi(3'b110, 3'd7, "prio7");
      do_ack(8'h01, "ack0");
      do_ack(8'h02, "ack1b");
      special_mask_mode = 1'b1;
      interrupt_mask    = 8'h01;
      #1;
      check_all("smm_comb");
      check("smm.h_const", 32'(highest_level_in_service), 32'h02);
      do_eoi(3'b001, 3'd0, "smm_ns_eoi");
      check("smm.any_const", 32'(in_service_any), 32'd0);
      special_mask_mode = 1'b0;
      #1;
      check_all("smm_off");
      do_eoi(3'b011, 3'd0, "sp_eoi0");

      do_ack(8'h04, "ack2");
      acknowledge = 1'b1;
      ack_vector  = 8'h04;
      eoi_valid   = 1'b1;
      eoi_cmd     = 3'b011;
      eoi_level   = 3'd2;
      step("ack_eoi_same");
      check("same.isr_const", 32'(in_service_register), 32'h04);

      acknowledge = 1'b1;
      ack_vector  = 8'h01;
      reset_n     = 1'b0;
      step("reset_mid");
      check("reset_mid.isr_const", 32'(in_service_register), 32'h00);
      reset_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         reset_n           = ($urandom_range(0, 49) != 0);
         auto_eoi          = ($urandom_range(0, 4) == 0);
         auto_rotate       = $urandom_range(0, 1) == 1;
         special_mask_mode = ($urandom_range(0, 3) == 0);
         interrupt_mask    = N'($urandom);
         eoi_valid         = ($urandom_range(0, 2) == 0);
         eoi_cmd           = 3'($urandom);
         eoi_level         = 3'($urandom);
         acknowledge       = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 5) == 0) ack_vector = N'($urandom);
         else                           ack_vector = N'(1) << $urandom_range(0, N - 1);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
